ocm_arbiter: RTL and testbench

Round-robin arbiter sharing the single-port on-chip RAM (OCM, 16k x 16, window 0x4000-0x7fff) between up to NUM_REQ masters (CPU, DMAC, future peripherals). Grants are combinational from registered arbitration state, giving zero-wait access to an uncontended master. Locked bursts are bounded by MAX_BURST to prevent starvation. Read data is returned with the RAM's fixed one-cycle latency and a per-master valid strobe. The block sits between the memory controller's OCM decode and the OCM RAM instance.

---
 rtl/ocm_arbiter_pkg.sv | 13 +
 rtl/ocm_arbiter_if.sv | 35 +++
 rtl/ocm_arbiter_rr_pick.sv | 32 +++
 rtl/ocm_arbiter.sv | 118 +++++++++++
 tb/tb_ocm_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ocm_arbiter_pkg.sv
// Shared OCM memory-map constants, also used by the memory controller's decode.
package ocm_arbiter_pkg;

    localparam logic [15:0] OCM_BASE         = 16'h4000;
    localparam int          OCM_ADDRESS_BITS = 14;
    localparam int          OCM_READ_LATENCY = 1;

    // True when a 16-bit CPU address falls inside the 0x4000-0x7fff OCM window.
    function automatic logic ocm_hit(input logic [15:0] cpu_addr);
        return cpu_addr[15:OCM_ADDRESS_BITS] == OCM_BASE[15:OCM_ADDRESS_BITS];
    endfunction

endpackage

// File: rtl/ocm_arbiter_if.sv
// Bundle of the per-master request bus and the OCM RAM port around ocm_arbiter.
interface ocm_arbiter_if
    import ocm_arbiter_pkg::*;
#(
    parameter int BITS         = 16,
    parameter int ADDRESS_BITS = OCM_ADDRESS_BITS,
    parameter int NUM_REQ      = 3
);
    // Handshake: master i raises REQ[i] and holds REQ/LOCK/WRb/ADDR/DIN stable
    // until GNT[i]; the access completes on the rising edge that ends a cycle
    // with REQ[i] & GNT[i], and a read returns VALID[i] with RDATA one cycle later.
    logic [NUM_REQ-1:0]              REQ;
    logic [NUM_REQ-1:0]              LOCK;
    logic [NUM_REQ-1:0]              WRb;
    logic [NUM_REQ*ADDRESS_BITS-1:0] ADDR;
    logic [NUM_REQ*BITS-1:0]         DIN;
    logic [NUM_REQ-1:0]              GNT;
    logic [NUM_REQ-1:0]              VALID;
    logic [BITS-1:0]                 RDATA;
    logic [ADDRESS_BITS-1:0]         MEM_ADDR;
    logic [BITS-1:0]                 MEM_DIN;
    logic                            MEM_WRb;
    logic [BITS-1:0]                 MEM_DOUT;

    modport slave (
        input  REQ, LOCK, WRb, ADDR, DIN, MEM_DOUT,
        output GNT, VALID, RDATA, MEM_ADDR, MEM_DIN, MEM_WRb
    );

    modport master (
        output REQ, LOCK, WRb, ADDR, DIN, MEM_DOUT,
        input  GNT, VALID, RDATA, MEM_ADDR, MEM_DIN, MEM_WRb
    );

endinterface

// File: rtl/ocm_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after ptr, ptr itself last.
module rr_pick #(
    parameter  int N  = 3,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    int cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = 0;
        for (int k = 1; k <= N; k++) begin
            cand = (int'(ptr) + k) % N;
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = IW'(cand);
            end
        end
        if (any) begin
            gnt[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/ocm_arbiter.sv
// Round-robin arbiter sharing the single-port OCM RAM, with bounded LOCK bursts
// and one-cycle read return. Grants are combinational from registered state.
module ocm_arbiter
    import ocm_arbiter_pkg::*;
#(
    parameter  int BITS         = 16,
    parameter  int ADDRESS_BITS = OCM_ADDRESS_BITS,
    parameter  int NUM_REQ      = 3,
    parameter  int MAX_BURST    = 8,
    localparam int IW           = $clog2(NUM_REQ),
    localparam int CW           = $clog2(MAX_BURST + 1)
) (
    input  logic          CLK,
    input  logic          RST,
    ocm_arbiter_if.slave  bus,
    output logic          dbg_lock_valid,
    output logic [IW-1:0] dbg_lock_owner,
    output logic [CW-1:0] dbg_burst_cnt,
    output logic [IW-1:0] dbg_last
);

    logic [IW-1:0]      last_q, last_d;
    logic               lock_valid_q, lock_valid_d;
    logic [IW-1:0]      lock_owner_q, lock_owner_d;
    logic [CW-1:0]      burst_cnt_q, burst_cnt_d;
    logic [NUM_REQ-1:0] valid_q, valid_d;

    logic [NUM_REQ-1:0] rr_gnt;
    logic [IW-1:0]      rr_idx;
    logic               rr_any;

    logic               win_any;
    logic [IW-1:0]      win_idx;
    logic [IW-1:0]      sel;
    logic [NUM_REQ-1:0] gnt;

    rr_pick #(.N(NUM_REQ)) u_rr_pick (
        .req (bus.REQ),
        .ptr (last_q),
        .gnt (rr_gnt),
        .idx (rr_idx),
        .any (rr_any)
    );

    // While a lock is held only the owner can win; everyone else is blocked.
    always_comb begin
        win_idx = rr_idx;
        win_any = rr_any;
        gnt     = '0;
        if (lock_valid_q) begin
            win_idx = lock_owner_q;
            win_any = bus.REQ[lock_owner_q];
        end
        if (RST) begin
            win_any = 1'b0;
        end
        if (win_any) begin
            gnt = lock_valid_q ? (NUM_REQ'(1) << lock_owner_q) : rr_gnt;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_q       <= IW'(NUM_REQ - 1);
            lock_valid_q <= 1'b0;
            lock_owner_q <= '0;
            burst_cnt_q  <= '0;
            valid_q      <= '0;
        end else begin
            last_q       <= last_d;
            lock_valid_q <= lock_valid_d;
            lock_owner_q <= lock_owner_d;
            burst_cnt_q  <= burst_cnt_d;
            valid_q      <= valid_d;
        end
    end

    always_comb begin
        last_d       = last_q;
        lock_valid_d = lock_valid_q;
        lock_owner_d = lock_owner_q;
        burst_cnt_d  = burst_cnt_q;
        valid_d      = gnt & bus.REQ & bus.WRb;
        if (win_any) begin
            last_d = win_idx;
            if (!lock_valid_q && bus.LOCK[win_idx]) begin
                lock_valid_d = 1'b1;
                lock_owner_d = win_idx;
                burst_cnt_d  = CW'(1);
            end else if (lock_valid_q && bus.LOCK[win_idx]) begin
                burst_cnt_d = burst_cnt_q + CW'(1);
            end else if (lock_valid_q) begin
                lock_valid_d = 1'b0;
            end
            // Forced release; last_d = owner hands priority to the others.
            if (burst_cnt_d == CW'(MAX_BURST)) begin
                lock_valid_d = 1'b0;
            end
        end else if (lock_valid_q && !bus.LOCK[lock_owner_q]) begin
            lock_valid_d = 1'b0;
        end
    end

    always_comb begin
        sel            = win_any ? win_idx : '0;
        bus.GNT        = gnt;
        bus.MEM_ADDR   = bus.ADDR[sel*ADDRESS_BITS +: ADDRESS_BITS];
        bus.MEM_DIN    = bus.DIN[sel*BITS +: BITS];
        bus.MEM_WRb    = win_any ? bus.WRb[win_idx] : 1'b1;
        bus.VALID      = valid_q;
        bus.RDATA      = bus.MEM_DOUT;
        dbg_lock_valid = lock_valid_q;
        dbg_lock_owner = lock_owner_q;
        dbg_burst_cnt  = burst_cnt_q;
        dbg_last       = last_q;
    end

endmodule

// File: tb/tb_ocm_arbiter.sv
// Bench for ocm_arbiter: directed scenarios plus randomized traffic against a
// behavioural model of the arbitration rules and a shadow copy of the RAM.
module tb_ocm_arbiter;

    localparam int N    = 3;
    localparam int AW   = 14;
    localparam int DW   = 16;
    localparam int MAXB = 8;
    localparam int IW   = $clog2(N);
    localparam int CW   = $clog2(MAXB + 1);

    logic          CLK = 1'b0;
    logic          rst;
    logic [N-1:0]  req_v, lock_v, wrb_v;
    logic [AW-1:0] addr_a [N];
    logic [DW-1:0] din_a  [N];
    logic          dbg_lock_valid;
    logic [IW-1:0] dbg_lock_owner;
    logic [CW-1:0] dbg_burst_cnt;
    logic [IW-1:0] dbg_last;

    int checks = 0;
    int errors = 0;

    ocm_arbiter_if #(.BITS(DW), .ADDRESS_BITS(AW), .NUM_REQ(N)) bus ();

    ocm_arbiter #(.BITS(DW), .ADDRESS_BITS(AW), .NUM_REQ(N), .MAX_BURST(MAXB)) dut (
        .CLK            (CLK),
        .RST            (rst),
        .bus            (bus.slave),
        .dbg_lock_valid (dbg_lock_valid),
        .dbg_lock_owner (dbg_lock_owner),
        .dbg_burst_cnt  (dbg_burst_cnt),
        .dbg_last       (dbg_last)
    );

    always #5 CLK = ~CLK;

    always_comb begin
        bus.REQ  = req_v;
        bus.LOCK = lock_v;
        bus.WRb  = wrb_v;
        bus.ADDR = '0;
        bus.DIN  = '0;
        for (int i = 0; i < N; i++) begin
            bus.ADDR[i*AW +: AW] = addr_a[i];
            bus.DIN[i*DW +: DW]  = din_a[i];
        end
    end

    // OCM RAM: synchronous, one-cycle read latency.
    logic [DW-1:0] ram [0:16383];
    always @(posedge CLK) begin
        bus.MEM_DOUT <= ram[bus.MEM_ADDR];
        if (!bus.MEM_WRb) ram[bus.MEM_ADDR] = bus.MEM_DIN;
    end

    // Behavioural reference model
    int            m_last, m_owner, m_cnt;
    bit            m_lock;
    logic [N-1:0]  m_valid;
    logic [DW-1:0] m_rdata;
    logic [DW-1:0] ref_mem [0:31];

    function automatic int model_winner();
        if (rst) return -1;
        if (m_lock) return req_v[m_owner] ? m_owner : -1;
        for (int k = 1; k <= N; k++) begin
            if (req_v[(m_last + k) % N]) return (m_last + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_last  = N - 1;
        m_lock  = 0;
        m_owner = 0;
        m_cnt   = 0;
        m_valid = '0;
    endtask

    task automatic model_advance(input int w);
        m_valid = '0;
        if (w >= 0) begin
            if (wrb_v[w]) begin
                m_valid[w] = 1'b1;
                m_rdata    = ref_mem[addr_a[w][4:0]];
            end else begin
                ref_mem[addr_a[w][4:0]] = din_a[w];
            end
            m_last = w;
            if (!m_lock && lock_v[w]) begin
                m_lock = 1; m_owner = w; m_cnt = 1;
            end else if (m_lock && lock_v[w]) begin
                m_cnt++;
            end else if (m_lock) begin
                m_lock = 0;
            end
            if (m_cnt == MAXB) m_lock = 0;
        end else if (m_lock && !lock_v[m_owner]) begin
            m_lock = 0;
        end
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        req_v  = '0;
        lock_v = '0;
        wrb_v  = '1;
        @(posedge CLK);
        @(posedge CLK);
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        req_v = '1;
        wrb_v = '0;
        @(negedge CLK);
        checks += 6;
        if (bus.GNT !== 3'b000) begin errors++; $display("FAIL reset_gnt: got %b expected 000", bus.GNT); end
        if (bus.VALID !== 3'b000) begin errors++; $display("FAIL reset_valid: got %b expected 000", bus.VALID); end
        if (bus.MEM_WRb !== 1'b1) begin errors++; $display("FAIL reset_memwrb: got %b expected 1", bus.MEM_WRb); end
        if (dbg_lock_valid !== 1'b0) begin errors++; $display("FAIL reset_lock: got %b expected 0", dbg_lock_valid); end
        if (dbg_last !== IW'(N - 1)) begin errors++; $display("FAIL reset_last: got %0d expected %0d", dbg_last, N - 1); end
        if (dbg_burst_cnt !== '0) begin errors++; $display("FAIL reset_burst: got %0d expected 0", dbg_burst_cnt); end
        do_reset();
    endtask

    task automatic test_single_master();
        for (int a = 0; a < 4; a++) ram[a] = 16'hA000 + 16'(a);
        do_reset();
        for (int k = 0; k < 5; k++) begin
            req_v = (k < 4) ? 3'b001 : 3'b000;
            wrb_v = 3'b111;
            addr_a[0] = AW'(k);
            @(negedge CLK);
            if (k < 4) begin
                checks += 2;
                if (bus.GNT !== 3'b001) begin errors++; $display("FAIL single_gnt[%0d]: got %b expected 001", k, bus.GNT); end
                if (bus.MEM_ADDR !== AW'(k)) begin errors++; $display("FAIL single_addr[%0d]: got %h expected %h", k, bus.MEM_ADDR, k); end
            end
            checks++;
            if (k > 0) begin
                checks++;
                if (bus.VALID !== 3'b001) begin errors++; $display("FAIL single_valid[%0d]: got %b expected 001", k, bus.VALID); end
                if (bus.RDATA !== 16'hA000 + 16'(k - 1)) begin errors++; $display("FAIL single_rdata[%0d]: got %h expected %h", k, bus.RDATA, 16'hA000 + 16'(k - 1)); end
            end else if (bus.VALID !== 3'b000) begin
                errors++; $display("FAIL single_valid0: got %b expected 000", bus.VALID);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_rotation();
        int ord [6] = '{0, 1, 2, 0, 1, 2};
        do_reset();
        req_v  = 3'b111;
        lock_v = 3'b000;
        wrb_v  = 3'($urandom_range(0, 7));
        for (int i = 0; i < N; i++) begin
            addr_a[i] = AW'($urandom_range(100, 200));
            din_a[i]  = DW'($urandom);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            checks += 2;
            if (bus.GNT !== (3'b001 << ord[c])) begin errors++; $display("FAIL rot_gnt[%0d]: got %b expected %b", c, bus.GNT, 3'b001 << ord[c]); end
            if (bus.MEM_WRb !== wrb_v[ord[c]]) begin errors++; $display("FAIL rot_memwrb[%0d]: got %b expected %b", c, bus.MEM_WRb, wrb_v[ord[c]]); end
            @(posedge CLK); #1;
            wrb_v[ord[c]] = 1'($urandom_range(0, 1));
        end
        req_v = '0;
    endtask

    task automatic test_bounded_lock();
        int exp_m [12] = '{1, 1, 1, 1, 1, 1, 1, 1, 2, 1, 1, 1};
        do_reset();
        req_v  = 3'b110;
        lock_v = 3'b010;
        wrb_v  = 3'b111;
        for (int c = 0; c < 12; c++) begin
            @(negedge CLK);
            checks++;
            if (bus.GNT !== (3'b001 << exp_m[c])) begin errors++; $display("FAIL lock_gnt[%0d]: got %b expected %b", c, bus.GNT, 3'b001 << exp_m[c]); end
            @(posedge CLK); #1;
        end
        checks += 2;
        if (dbg_lock_valid !== 1'b1) begin errors++; $display("FAIL lock_relock: got %b expected 1", dbg_lock_valid); end
        if (dbg_burst_cnt !== CW'(3)) begin errors++; $display("FAIL lock_cnt: got %0d expected 3", dbg_burst_cnt); end
        req_v  = '0;
        lock_v = '0;
    endtask

    task automatic test_lock_release();
        bit lk [4] = '{1, 1, 0, 0};
        bit rq [4] = '{1, 1, 1, 0};
        logic [2:0] eg [4] = '{3'b001, 3'b001, 3'b001, 3'b010};
        do_reset();
        wrb_v = 3'b111;
        for (int c = 0; c < 4; c++) begin
            req_v  = {1'b0, 1'b1, rq[c]};
            lock_v = {2'b00, lk[c]};
            @(negedge CLK);
            checks++;
            if (bus.GNT !== eg[c]) begin errors++; $display("FAIL rel_gnt[%0d]: got %b expected %b", c, bus.GNT, eg[c]); end
            if (c == 1 || c == 3) begin
                checks++;
                if (dbg_lock_valid !== (c == 1)) begin errors++; $display("FAIL rel_lock[%0d]: got %b expected %b", c, dbg_lock_valid, c == 1); end
            end
            @(posedge CLK); #1;
        end
        req_v  = '0;
        lock_v = '0;
    endtask

    task automatic test_write_read();
        do_reset();
        req_v = 3'b100; wrb_v = 3'b011; addr_a[2] = 14'h0010; din_a[2] = 16'h1234;
        @(negedge CLK);
        checks += 5;
        if (bus.GNT !== 3'b100) begin errors++; $display("FAIL wr_gnt: got %b expected 100", bus.GNT); end
        if (bus.MEM_WRb !== 1'b0) begin errors++; $display("FAIL wr_memwrb: got %b expected 0", bus.MEM_WRb); end
        if (bus.MEM_ADDR !== 14'h0010) begin errors++; $display("FAIL wr_addr: got %h expected 0010", bus.MEM_ADDR); end
        if (bus.MEM_DIN !== 16'h1234) begin errors++; $display("FAIL wr_din: got %h expected 1234", bus.MEM_DIN); end
        if (bus.VALID !== 3'b000) begin errors++; $display("FAIL wr_valid0: got %b expected 000", bus.VALID); end
        @(posedge CLK); #1;
        req_v = 3'b001; wrb_v = 3'b111; addr_a[0] = 14'h0010;
        @(negedge CLK);
        checks += 3;
        if (bus.GNT !== 3'b001) begin errors++; $display("FAIL rd_gnt: got %b expected 001", bus.GNT); end
        if (bus.MEM_WRb !== 1'b1) begin errors++; $display("FAIL rd_memwrb: got %b expected 1", bus.MEM_WRb); end
        if (bus.VALID !== 3'b000) begin errors++; $display("FAIL wr_valid1: got %b expected 000", bus.VALID); end
        @(posedge CLK); #1;
        req_v = 3'b000;
        @(negedge CLK);
        checks += 2;
        if (bus.VALID !== 3'b001) begin errors++; $display("FAIL rd_valid: got %b expected 001", bus.VALID); end
        if (bus.RDATA !== 16'h1234) begin errors++; $display("FAIL rd_rdata: got %h expected 1234", bus.RDATA); end
        @(posedge CLK); #1;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        req_v = 3'b010; lock_v = 3'b010; wrb_v = 3'b111; addr_a[1] = 14'h0005;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            checks++;
            if (bus.GNT !== 3'b010) begin errors++; $display("FAIL mid_gnt[%0d]: got %b expected 010", c, bus.GNT); end
            if (c == 2) begin
                checks += 2;
                if (bus.VALID !== 3'b010) begin errors++; $display("FAIL mid_valid_pre: got %b expected 010", bus.VALID); end
                if (dbg_lock_valid !== 1'b1) begin errors++; $display("FAIL mid_lock_pre: got %b expected 1", dbg_lock_valid); end
            end else begin
                @(posedge CLK); #1;
                req_v = 3'b011;
                addr_a[1] = addr_a[1] + 14'd1;
            end
        end
        #2 rst = 1'b1;
        #1;
        checks += 3;
        if (bus.GNT !== 3'b000) begin errors++; $display("FAIL mid_rst_gnt: got %b expected 000", bus.GNT); end
        if (bus.VALID !== 3'b000) begin errors++; $display("FAIL mid_rst_valid: got %b expected 000", bus.VALID); end
        if (dbg_lock_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_lock: got %b expected 0", dbg_lock_valid); end
        @(posedge CLK); #1;
        rst = 1'b0; lock_v = 3'b000; req_v = 3'b011;
        @(negedge CLK);
        checks += 2;
        if (bus.GNT !== 3'b001) begin errors++; $display("FAIL mid_after_gnt: got %b expected 001", bus.GNT); end
        if (bus.VALID !== 3'b000) begin errors++; $display("FAIL mid_after_valid: got %b expected 000", bus.VALID); end
        @(posedge CLK); #1;
        req_v = '0;
    endtask

    task automatic test_random();
        int w;
        logic [N-1:0] eg;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic ew;
        do_reset();
        for (int a = 0; a < 32; a++) ref_mem[a] = ram[a];
        for (int i = 0; i < N; i++) begin
            addr_a[i] = '0;
            din_a[i]  = '0;
        end
        for (int c = 0; c < 400; c++) begin
            @(negedge CLK);
            w  = model_winner();
            eg = (w >= 0) ? (N'(1) << w) : '0;
            ea = addr_a[(w >= 0) ? w : 0];
            ed = din_a[(w >= 0) ? w : 0];
            ew = (w >= 0) ? wrb_v[w] : 1'b1;
            checks += 5;
            if (bus.GNT !== eg) begin errors++; $display("FAIL rnd_gnt[%0d]: got %b expected %b", c, bus.GNT, eg); end
            if (bus.MEM_WRb !== ew) begin errors++; $display("FAIL rnd_memwrb[%0d]: got %b expected %b", c, bus.MEM_WRb, ew); end
            if (bus.MEM_ADDR !== ea) begin errors++; $display("FAIL rnd_addr[%0d]: got %h expected %h", c, bus.MEM_ADDR, ea); end
            if (bus.MEM_DIN !== ed) begin errors++; $display("FAIL rnd_din[%0d]: got %h expected %h", c, bus.MEM_DIN, ed); end
            if (bus.VALID !== m_valid) begin errors++; $display("FAIL rnd_valid[%0d]: got %b expected %b", c, bus.VALID, m_valid); end
            if (m_valid != '0) begin
                checks++;
                if (bus.RDATA !== m_rdata) begin errors++; $display("FAIL rnd_rdata[%0d]: got %h expected %h", c, bus.RDATA, m_rdata); end
            end
            @(posedge CLK);
            model_advance(w);
            #1;
            for (int i = 0; i < N; i++) begin
                if (!req_v[i] || w == i) begin
                    req_v[i]  = ($urandom_range(0, 3) != 0);
                    lock_v[i] = req_v[i] && ($urandom_range(0, 3) == 0);
                    wrb_v[i]  = 1'($urandom_range(0, 1));
                    addr_a[i] = AW'($urandom_range(0, 31));
                    din_a[i]  = DW'($urandom);
                end
            end
        end
        req_v  = '0;
        lock_v = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        req_v  = '0;
        lock_v = '0;
        wrb_v  = '1;
        for (int i = 0; i < N; i++) begin
            addr_a[i] = '0;
            din_a[i]  = '0;
        end
        model_reset();
        test_reset();
        test_single_master();
        test_rotation();
        test_bounded_lock();
        test_lock_release();
        test_write_read();
        test_reset_mid_burst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
